// File: rtl/seq_pkg.sv
// seq_pkg: word width, slot count and FSM encoding shared by the sequencer output path.
package seq_pkg;
    localparam int WORD_W    = 16;
    localparam int MAX_SLOTS = 16;
    localparam int ADDR_W    = $clog2(MAX_SLOTS);
    localparam int BIT_W     = $clog2(WORD_W);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/seq_out_bank.sv
// seq_out_bank: two-bank 16x16 register file, one write port and one combinational read port.
// Build option SEQ_OUT_CLEAR_EN: zero one bank on i_clr and both banks on reset.
module seq_out_bank
    import seq_pkg::*;
(
    input  logic              i_ck,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic              i_wbank,
    input  logic [ADDR_W-1:0] i_waddr,
    input  word_t             i_wdata,
    input  logic              i_clr,
    input  logic              i_clr_bank,
    input  logic              i_rbank,
    input  logic [ADDR_W-1:0] i_raddr,
    output word_t             o_rdata
);
    word_t r_mem [2][MAX_SLOTS];

`ifdef SEQ_OUT_CLEAR_EN
    // The cleared bank is never the write bank of the same cycle, so clear and write cannot collide.
    always_ff @(negedge i_ck) begin
        if (!i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < MAX_SLOTS; w++) begin
                    r_mem[b][w] <= '0;
                end
            end
        end else begin
            if (i_clr) begin
                for (int w = 0; w < MAX_SLOTS; w++) begin
                    r_mem[i_clr_bank][w] <= '0;
                end
            end
            if (i_we) begin
                r_mem[i_wbank][i_waddr] <= i_wdata;
            end
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr ^ i_clr_bank;

    always_ff @(negedge i_ck) begin
        if (i_rst && i_we) begin
            r_mem[i_wbank][i_waddr] <= i_wdata;
        end
    end
`endif

    assign o_rdata = r_mem[i_rbank][i_raddr];
endmodule

// File: rtl/seq_out_buffer.sv
// seq_out_buffer: double-buffered TDM serialiser between the sequencer and the serial link.
// Build option SEQ_OUT_CLEAR_EN (see seq_out_bank) zeroes stale channels on swap and reset.
//
// state    | meaning
// ST_IDLE  | no frame in flight, sdo/fs held low, waiting for tx_start
// ST_SHIFT | shifting CHANNELS*16 bits MSB first, one per bit_en
module seq_out_buffer
    import seq_pkg::*;
#(
    parameter int CHANNELS = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_we,
    input  logic              done,
    input  logic              tx_start,
    input  logic              bit_en,
    output logic              sdo,
    output logic              fs,
    output logic              busy,
    output logic              overrun,
    output logic              sync_err
);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(CHANNELS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);

    logic [0:0]        r_state;
    logic              r_wsel;
    logic              r_pending;
    logic              r_done_q;
    logic              r_overrun;
    logic              r_sync_err;
    logic [WORD_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit;
    logic [ADDR_W-1:0] r_slot;

    logic              w_idle;
    logic              w_done_rise;
    logic              w_swap;
    logic              w_rbank;
    logic [ADDR_W-1:0] w_raddr;
    logic [WORD_W-1:0] w_rdata;
    logic              w_last_bit;
    logic              w_last_slot;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_done_rise = done & ~r_done_q;
    assign w_swap      = tx_start & w_idle & r_pending;
    // In IDLE the read port already points at the post-swap read bank so slot 0 loads in the swap cycle.
    assign w_rbank     = ~(r_wsel ^ (w_idle & r_pending));
    assign w_raddr     = w_idle ? '0 : r_slot + ADDR_W'(1);
    assign w_last_bit  = (r_bit == LAST_BIT);
    assign w_last_slot = (r_slot == LAST_SLOT);

    seq_out_bank u_bank (
        .i_ck       (ck),
        .i_rst      (rst),
        .i_we       (wr_we),
        .i_wbank    (r_wsel),
        .i_waddr    (wr_addr),
        .i_wdata    (wr_data),
        .i_clr      (w_swap),
        .i_clr_bank (~r_wsel),
        .i_rbank    (w_rbank),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata)
    );

    always_ff @(negedge ck) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wsel     <= 1'b0;
            r_pending  <= 1'b0;
            r_done_q   <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_slot     <= '0;
        end else begin
            r_done_q <= done;
            if (w_swap) begin
                r_wsel    <= ~r_wsel;
                r_pending <= 1'b0;
            end else if (w_done_rise) begin
                r_pending <= 1'b1;
            end
            if (w_done_rise && r_pending && !w_swap) begin
                r_overrun <= 1'b1;
            end
            if (tx_start && !w_idle) begin
                r_sync_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        r_state <= ST_SHIFT;
                        r_shift <= w_rdata;
                        r_bit   <= '0;
                        r_slot  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        if (!w_last_bit) begin
                            r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                            r_bit   <= r_bit + BIT_W'(1);
                        end else if (w_last_slot) begin
                            r_state <= ST_IDLE;
                            r_shift <= '0;
                            r_bit   <= '0;
                            r_slot  <= '0;
                        end else begin
                            r_shift <= w_rdata;
                            r_bit   <= '0;
                            r_slot  <= r_slot + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == ST_SHIFT);
    assign sdo      = busy & r_shift[WORD_W-1];
    assign fs       = busy & (r_slot == '0) & (r_bit == '0);
    assign overrun  = r_overrun;
    assign sync_err = r_sync_err;
endmodule

// File: tb/tb_seq_out_buffer.sv
// tb_seq_out_buffer: scoreboard bench; expected frame bits are queued from a bank model at tx_start.
module tb_seq_out_buffer;
    localparam int CH = 16;

    logic        ck       = 1'b0;
    logic        rst      = 1'b0;
    logic [3:0]  wr_addr  = '0;
    logic [15:0] wr_data  = '0;
    logic        wr_we    = 1'b0;
    logic        done     = 1'b0;
    logic        tx_start = 1'b0;
    logic        bit_en   = 1'b0;
    logic        sdo, fs, busy, overrun, sync_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_mem [2][16];
    logic        m_wsel    = 1'b0;
    logic        m_pending = 1'b0;
    logic [1:0]  exp_q [$];
    logic [31:0] cap = '0;

    always #5 ck = ~ck;

    seq_out_buffer #(.CHANNELS(CH)) dut (
        .ck       (ck),
        .rst      (rst),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_we    (wr_we),
        .done     (done),
        .tx_start (tx_start),
        .bit_en   (bit_en),
        .sdo      (sdo),
        .fs       (fs),
        .busy     (busy),
        .overrun  (overrun),
        .sync_err (sync_err)
    );

    task automatic model_reset();
        m_wsel    = 1'b0;
        m_pending = 1'b0;
        exp_q.delete();
`ifdef SEQ_OUT_CLEAR_EN
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 16; w++) m_mem[b][w] = '0;
`endif
    endtask

    task automatic write_ch(input logic [3:0] a, input logic [15:0] d);
        @(posedge ck);
        wr_we = 1'b1; wr_addr = a; wr_data = d;
        m_mem[m_wsel][a] = d;
        @(posedge ck);
        wr_we = 1'b0;
    endtask

    task automatic write_all(input logic [15:0] seed, input bit skip5);
        for (int c = 0; c < 16; c++)
            if (!(skip5 && c == 5)) write_ch(4'(c), seed + 16'(c) * 16'h0111);
    endtask

    task automatic seq_done();
        @(posedge ck);
        done = 1'b1;
        m_pending = 1'b1;
        @(posedge ck);
        @(posedge ck);
        done = 1'b0;
        @(posedge ck);
    endtask

    task automatic start_frame(input bit with_be);
        if (m_pending) begin
            m_wsel    = ~m_wsel;
            m_pending = 1'b0;
`ifdef SEQ_OUT_CLEAR_EN
            for (int w = 0; w < 16; w++) m_mem[m_wsel][w] = '0;
`endif
        end
        for (int s = 0; s < CH; s++)
            for (int b = 0; b < 16; b++)
                exp_q.push_back({m_mem[~m_wsel][s][15-b], (s == 0 && b == 0)});
        @(posedge ck);
        tx_start = 1'b1; bit_en = with_be;
        @(posedge ck);
        tx_start = 1'b0; bit_en = 1'b0;
    endtask

    task automatic run_bits(input int n, input int sync_at);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty at step %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({busy, sdo, fs} !== {1'b1, e}) begin
                    bad++;
                    $display("FAIL frame_bit step %0d busy/sdo/fs got=%b want=%b", i, {busy, sdo, fs}, {1'b1, e});
                end
            end
            cap = {cap[30:0], sdo};
            bit_en = 1'b1; tx_start = (i == sync_at);
            @(posedge ck);
            bit_en = 1'b0; tx_start = 1'b0;
        end
    endtask

    task automatic frame_end_check(input string tag);
        total++;
        if ({busy, sdo, fs} !== 3'b000) begin
            bad++;
            $display("FAIL %s_idle busy/sdo/fs got=%b want=000", tag, {busy, sdo, fs});
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_left got=%0d want=0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge ck);
        total++;
        if ({busy, sdo, fs} !== 3'b000) begin
            bad++; $display("FAIL reset_out busy/sdo/fs got=%b want=000", {busy, sdo, fs});
        end
        total++;
        if ({overrun, sync_err} !== 2'b00) begin
            bad++; $display("FAIL reset_flags ovr/serr got=%b want=00", {overrun, sync_err});
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        write_all(16'h1000, 1'b0);
        write_ch(4'd0, 16'h8001);
        write_ch(4'd1, 16'h1234);
        seq_done();
        start_frame(1'b0);
        run_bits(32, -1);
        total++;
        if (cap !== 32'h8001_1234) begin
            bad++; $display("FAIL basic_first32 got=%h want=80011234", cap);
        end
        run_bits(CH * 16 - 32, -1);
        frame_end_check("basic");
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL basic_overrun got=%b want=0", overrun);
        end
    endtask

    task automatic test_overrun();
        write_all(16'h2000, 1'b0);
        seq_done();
        write_all(16'h3000, 1'b0);
        seq_done();
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set got=%b want=1", overrun);
        end
        start_frame(1'b0);
        run_bits(16, -1);
        total++;
        if (cap[15:0] !== 16'h3000) begin
            bad++; $display("FAIL overrun_newest ch0 got=%h want=3000", cap[15:0]);
        end
        run_bits(CH * 16 - 16, -1);
        frame_end_check("overrun");
    endtask

    task automatic test_sync_err();
        total++;
        if (sync_err !== 1'b0) begin
            bad++; $display("FAIL sync_pre got=%b want=0", sync_err);
        end
        start_frame(1'b0);
        run_bits(CH * 16, 100);
        frame_end_check("sync");
        total++;
        if (sync_err !== 1'b1) begin
            bad++; $display("FAIL sync_set got=%b want=1", sync_err);
        end
    endtask

    task automatic test_repeat();
        start_frame(1'b1);
        run_bits(CH * 16, -1);
        frame_end_check("repeat");
    endtask

    task automatic test_clear();
        logic [15:0] want5;
`ifdef SEQ_OUT_CLEAR_EN
        want5 = 16'h0000;
`else
        want5 = 16'h3555;
`endif
        write_all(16'h4000, 1'b0);
        seq_done();
        start_frame(1'b0);
        run_bits(CH * 16, -1);
        frame_end_check("clear1");
        write_all(16'h5000, 1'b1);
        seq_done();
        start_frame(1'b0);
        run_bits(6 * 16, -1);
        total++;
        if (cap[15:0] !== want5) begin
            bad++; $display("FAIL clear_ch5 got=%h want=%h", cap[15:0], want5);
        end
        run_bits(CH * 16 - 6 * 16, -1);
        frame_end_check("clear2");
    endtask

    task automatic test_reset_mid();
        start_frame(1'b0);
        run_bits(40, -1);
        rst = 1'b0;
        @(posedge ck);
        rst = 1'b1;
        model_reset();
        total++;
        if ({busy, sdo, fs} !== 3'b000) begin
            bad++; $display("FAIL rstmid_out busy/sdo/fs got=%b want=000", {busy, sdo, fs});
        end
        total++;
        if ({overrun, sync_err} !== 2'b00) begin
            bad++; $display("FAIL rstmid_flags ovr/serr got=%b want=00", {overrun, sync_err});
        end
        start_frame(1'b0);
        run_bits(CH * 16, -1);
        frame_end_check("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_sync_err();
        test_repeat();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
